// File: rtl/axis_lane_accumulator.sv
// axis_lane_accumulator: per-lane AXI-Stream accumulator summing NO_OF_STEPS beats or until s_last
module axis_lane_accumulator #(
  parameter int WIDTH = 3,
  parameter int LANES = 2,
  parameter int NO_OF_STEPS = 4,
  parameter bit SIGNED = 0,
  localparam int OUT_WIDTH = WIDTH + $clog2(NO_OF_STEPS),
  localparam int CNT_WIDTH = $clog2(NO_OF_STEPS + 1)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [LANES*WIDTH-1:0]       s_data,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [LANES*OUT_WIDTH-1:0]   m_data,
  output logic                         m_last,
  output logic [CNT_WIDTH-1:0]         m_count
);
  logic [LANES-1:0][OUT_WIDTH-1:0] ext, sum, acc_q, acc_d, data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, count_q, count_d;
  logic valid_q, valid_d, last_q, last_d, fire, close;
  assign s_ready = rstn && (!valid_q || m_ready);
  assign fire = s_valid && s_ready;
  assign close = fire && (s_last || cnt_q == CNT_WIDTH'(NO_OF_STEPS - 1));
  assign m_valid = valid_q;
  assign m_data = data_q;
  assign m_last = last_q;
  assign m_count = count_q;
  always_comb begin
    ext = '0;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      ext[i] = OUT_WIDTH'({{OUT_WIDTH{SIGNED && s_data[i*WIDTH+WIDTH-1]}}, s_data[i*WIDTH +: WIDTH]});
      sum[i] = (cnt_q == '0 ? '0 : acc_q[i]) + ext[i];
    end
    acc_d = fire ? sum : acc_q;
    data_d = close ? sum : data_q;
    cnt_d = fire ? (close ? '0 : cnt_q + 1'b1) : cnt_q;
    count_d = close ? cnt_q + 1'b1 : count_q;
    last_d = close ? s_last : last_q;
    valid_d = close || (valid_q && !m_ready);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      count_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      count_q <= count_d;
      last_q <= last_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_axis_lane_accumulator.sv
// tb_axis_lane_accumulator: lockstep unsigned/wide/signed accumulators against a scoreboard model
module tb_axis_lane_accumulator;
  typedef struct {
    bit v;
    bit last;
    bit mr;
    int d0;
    int d1;
    int e0;
    int e2;
  } vec_t;
  typedef struct packed {
    logic [5:0][31:0] d;
    logic [31:0] c;
    logic l;
  } exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [5:0] sd0 = '0;
  logic [7:0] sd1 = '0;
  logic sr [3];
  logic mv [3];
  logic ml [3];
  logic [2:0] mc [3];
  logic [9:0] md0, md2;
  logic [11:0] md1;
  int passed = 0, total = 0;
  exp_t q[$];
  int acc [3][2];
  int cnt = 0;
  bit emv = 0;
  vec_t tv [37];
  always #5 clk = ~clk;
  axis_lane_accumulator #(.WIDTH(3), .LANES(2), .NO_OF_STEPS(4), .SIGNED(0)) u0 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(sr[0]), .s_data(sd0), .s_last(s_last),
    .m_valid(mv[0]), .m_ready(m_ready), .m_data(md0), .m_last(ml[0]), .m_count(mc[0]));
  axis_lane_accumulator #(.WIDTH(4), .LANES(2), .NO_OF_STEPS(4), .SIGNED(0)) u1 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(sr[1]), .s_data(sd1), .s_last(s_last),
    .m_valid(mv[1]), .m_ready(m_ready), .m_data(md1), .m_last(ml[1]), .m_count(mc[1]));
  axis_lane_accumulator #(.WIDTH(3), .LANES(2), .NO_OF_STEPS(4), .SIGNED(1)) u2 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(sr[2]), .s_data(sd0), .s_last(s_last),
    .m_valid(mv[2]), .m_ready(m_ready), .m_data(md2), .m_last(ml[2]), .m_count(mc[2]));
  task automatic cmp(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
  endtask
  function automatic logic [31:0] lane(int k, int l);
    case (k)
      0: return 32'(md0[l*5 +: 5]);
      1: return 32'(md1[l*6 +: 6]);
      default: return 32'(md2[l*5 +: 5]);
    endcase
  endfunction
  function automatic int mask(int k);
    return k == 1 ? 63 : 31;
  endfunction
  function automatic int ext(int v, int k);
    int w = k == 1 ? 4 : 3;
    int m = v & ((1 << w) - 1);
    if (k == 2 && m >= (1 << (w - 1))) m -= (1 << w);
    return m;
  endfunction
  task automatic do_reset();
    s_valid = 1'b0;
    rstn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("u%0d.rst.s_ready", k), 32'(sr[k]), 0);
      cmp($sformatf("u%0d.rst.m_valid", k), 32'(mv[k]), 0);
      cmp($sformatf("u%0d.rst.m_last", k), 32'(ml[k]), 0);
      cmp($sformatf("u%0d.rst.m_count", k), 32'(mc[k]), 0);
      for (int l = 0; l < 2; l++) cmp($sformatf("u%0d.rst.m_data%0d", k, l), lane(k, l), 0);
    end
    q.delete();
    cnt = 0;
    emv = 0;
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask
  task automatic step(bit v, bit last, bit mr, int d0, int d1);
    bit rdy, close;
    exp_t e;
    s_valid = v;
    s_last = last;
    m_ready = mr;
    sd0 = {3'(d1), 3'(d0)};
    sd1 = {4'(d1), 4'(d0)};
    #1;
    rdy = !emv || mr;
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("u%0d.s_ready", k), 32'(sr[k]), 32'(rdy));
      cmp($sformatf("u%0d.m_valid", k), 32'(mv[k]), 32'(emv));
      if (emv) begin
        for (int l = 0; l < 2; l++)
          cmp($sformatf("u%0d.m_data%0d", k, l), lane(k, l), q[0].d[k*2+l] & mask(k));
        cmp($sformatf("u%0d.m_count", k), 32'(mc[k]), q[0].c);
        cmp($sformatf("u%0d.m_last", k), 32'(ml[k]), 32'(q[0].l));
      end
    end
    if (emv && mr) void'(q.pop_front());
    close = 0;
    e = '0;
    if (v && rdy) begin
      close = last || cnt == 3;
      for (int k = 0; k < 3; k++)
        for (int l = 0; l < 2; l++) begin
          acc[k][l] = (cnt == 0 ? 0 : acc[k][l]) + ext(l == 0 ? d0 : d1, k);
          e.d[k*2+l] = acc[k][l];
        end
      e.c = cnt + 1;
      e.l = last;
      if (close) q.push_back(e);
      cnt = close ? 0 : cnt + 1;
    end
    emv = close || (emv && !mr);
    @(posedge clk);
    #1;
  endtask
  initial begin
    tv = '{
      '{1,0,1,0,7,-1,-1}, '{1,0,1,1,7,-1,-1}, '{1,0,1,2,7,-1,-1}, '{1,0,1,3,7,6,6},
      '{1,0,1,5,0,-1,-1}, '{1,1,1,6,0,11,27},
      '{1,0,1,1,1,-1,-1}, '{1,0,1,1,1,-1,-1}, '{1,0,1,1,1,-1,-1}, '{1,0,1,1,1,4,4},
      '{1,0,1,2,0,-1,-1}, '{1,0,1,2,0,-1,-1}, '{1,0,1,2,0,-1,-1}, '{1,1,1,2,0,8,8},
      '{1,0,1,1,2,-1,-1}, '{1,0,1,1,2,-1,-1}, '{1,0,1,1,2,-1,-1}, '{1,0,0,1,2,4,4},
      '{1,0,0,7,7,4,4}, '{1,0,0,7,7,4,4}, '{1,0,0,7,7,4,4}, '{1,0,0,7,7,4,4}, '{1,0,0,7,7,4,4},
      '{1,0,1,3,3,-1,-1}, '{1,0,1,3,3,-1,-1}, '{1,0,1,3,3,-1,-1}, '{1,0,1,3,3,12,12},
      '{1,0,1,4,4,-1,-1}, '{1,0,1,4,4,-1,-1}, '{1,0,1,4,4,-1,-1}, '{1,0,1,4,4,16,16},
      '{1,0,1,3,0,-1,-1}, '{1,0,1,7,0,-1,-1}, '{0,1,1,5,5,-1,-1}, '{1,0,1,6,0,-1,-1},
      '{1,0,1,1,0,17,1},
      '{0,0,1,0,0,-1,-1}
    };
    #2;
    do_reset();
    foreach (tv[i]) begin
      step(tv[i].v, tv[i].last, tv[i].mr, tv[i].d0, tv[i].d1);
      if (tv[i].e0 >= 0) begin
        cmp($sformatf("vec%0d.u0.lane0", i), lane(0, 0), 32'(tv[i].e0));
        cmp($sformatf("vec%0d.u2.lane0", i), lane(2, 0), 32'(tv[i].e2));
      end
    end
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 1, i, i);
      if (i % 4 == 3) cmp($sformatf("stream%0d.u1.lane0", i), lane(1, 0), 32'(6 + 16 * (i / 4)));
    end
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 1);
    cmp("post_rst.u0.lane0", lane(0, 0), 4);
    cmp("post_rst.u0.m_count", 32'(mc[0]), 4);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
